// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues word fetches on the sram-like instruction bus and
// buffers returned words in order for decode, flushing on redirect.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_adel
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_HALT  = 1'b1;
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

  logic [0:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;
  logic          stale_q, stale_d;
  logic [AW:0]   out_cnt_q, out_cnt_d;
  logic [AW:0]   drop_q, drop_d;
  logic [AW:0]   occ_q, occ_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW-1:0] pf_head_q, pf_head_d, pf_tail_q, pf_tail_d;

  logic [31:0] instr_mem_q [DEPTH];
  logic [31:0] pc_mem_q    [DEPTH];
  logic        adel_mem_q  [DEPTH];
  logic [31:0] pcf_mem_q   [DEPTH];

  logic        accept, pop, resp_push, adel_push, push;
  logic [31:0] push_instr, push_pc;

  assign out_valid = (occ_q != '0);
  assign out_instr = out_valid ? instr_mem_q[head_q] : '0;
  assign out_pc    = out_valid ? pc_mem_q[head_q]    : '0;
  assign out_adel  = out_valid ? adel_mem_q[head_q]  : 1'b0;
  assign inst_req  = req_q;
  assign inst_addr = addr_q;

  always_comb begin
    accept     = req_q & inst_addr_ok;
    pop        = out_valid & out_ready;
    resp_push  = inst_data_ok && (drop_q == '0) && !redirect_valid;
    // Misaligned pc is only enqueued once every older fetch has drained, keeping order.
    adel_push  = (state_q == ST_FETCH) && (fetch_pc_q[1:0] != 2'b00) && !req_q &&
                 (out_cnt_q == '0) && !inst_data_ok && (occ_q < DEPTH_C) && !redirect_valid;
    push       = resp_push | adel_push;
    push_instr = resp_push ? inst_rdata : '0;
    push_pc    = resp_push ? pcf_mem_q[pf_head_q] : fetch_pc_q;

    out_cnt_d = out_cnt_q;
    case ({accept, inst_data_ok})
      2'b10:   out_cnt_d = out_cnt_q + (AW+1)'(1);
      2'b01:   out_cnt_d = out_cnt_q - (AW+1)'(1);
      default: out_cnt_d = out_cnt_q;
    endcase
    pf_tail_d = accept       ? pf_tail_q + AW'(1) : pf_tail_q;
    pf_head_d = inst_data_ok ? pf_head_q + AW'(1) : pf_head_q;

    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    stale_d    = stale_q;
    drop_d     = drop_q;
    occ_d      = occ_q;
    head_d     = head_q;
    tail_d     = tail_q;

    if (redirect_valid) begin
      state_d    = ST_FETCH;
      fetch_pc_d = redirect_pc;
      occ_d      = '0;
      head_d     = '0;
      tail_d     = '0;
      // A held request still goes out with its old address; its response must be dropped too.
      stale_d    = req_q & ~inst_addr_ok;
      drop_d     = out_cnt_d + (AW+1)'(stale_d);
    end else begin
      if (accept) begin
        stale_d = 1'b0;
        if (!stale_q) fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (inst_data_ok && (drop_q != '0)) drop_d = drop_q - (AW+1)'(1);
      if (adel_push) state_d = ST_HALT;
      head_d = pop  ? head_q + AW'(1) : head_q;
      tail_d = push ? tail_q + AW'(1) : tail_q;
      case ({push, pop})
        2'b10:   occ_d = occ_q + (AW+1)'(1);
        2'b01:   occ_d = occ_q - (AW+1)'(1);
        default: occ_d = occ_q;
      endcase
    end

    if (req_q && !accept) begin
      req_d  = 1'b1;
      addr_d = addr_q;
    end else begin
      req_d  = (state_d == ST_FETCH) && (fetch_pc_d[1:0] == 2'b00) &&
               (({1'b0, occ_d} + {1'b0, out_cnt_d}) < DEPTH_W);
      addr_d = req_d ? fetch_pc_d : addr_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_FETCH;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      stale_q    <= 1'b0;
      out_cnt_q  <= '0;
      drop_q     <= '0;
      occ_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      pf_head_q  <= '0;
      pf_tail_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      stale_q    <= stale_d;
      out_cnt_q  <= out_cnt_d;
      drop_q     <= drop_d;
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      pf_head_q  <= pf_head_d;
      pf_tail_q  <= pf_tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[tail_q] <= push_instr;
      pc_mem_q[tail_q]    <= push_pc;
      adel_mem_q[tail_q]  <= adel_push;
    end
    if (accept) pcf_mem_q[pf_tail_q] <= addr_q;
  end
endmodule
